fir_coef_ctrl: RTL and testbench

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

---
 rtl/fir_coef_ctrl.sv | 138 +++++++++++++
 tb/tb_fir_coef_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_ctrl.sv
// FIR coefficient bank controller: shadow loading, atomic swap into the active bank, pipeline flush.
// Optional readback port enabled by defining FIR_COEF_READBACK_EN.
module fir_coef_ctrl #(
  parameter int NTAPS     = 16,
  parameter int DW        = 16,
  parameter int FLUSH_LEN = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic                  commit,
  input  logic                  abort,
  output logic                  commit_err,
  output logic [NTAPS*DW-1:0]   coef_o,
  output logic                  flush,
  output logic                  yn_valid,
  output logic                  busy,
  output logic [7:0]            swap_cnt
`ifdef FIR_COEF_READBACK_EN
  ,
  input  logic [3:0]            rd_addr,
  output logic [DW-1:0]         rd_data
`endif
);

  localparam int CW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWAP,
    FLUSH
  } state_t;

  state_t          state;
  logic [DW-1:0]   shadow [NTAPS];
  logic [DW-1:0]   active [NTAPS];
  logic [NTAPS-1:0] mask;
  logic [NTAPS-1:0] wr_onehot;
  logic [NTAPS-1:0] mask_next;
  logic [CW-1:0]   flush_cnt;
  logic            addr_ok;
  logic            wr_fire;

  // A write landing in the same cycle as commit counts toward completeness.
  always_comb begin
    addr_ok   = int'(wr_addr) < NTAPS;
    wr_fire   = wr_valid && wr_ready && addr_ok;
    wr_onehot = '0;
    if (wr_fire) wr_onehot = NTAPS'(1) << wr_addr;
    mask_next = mask | wr_onehot;
  end

  always_comb begin
    coef_o = '0;
    for (int unsigned i = 0; i < NTAPS; i++) coef_o[DW*i +: DW] = active[i];
  end

  // Outputs are registered alongside each state transition so they track the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask       <= '0;
      flush_cnt  <= '0;
      swap_cnt   <= '0;
      commit_err <= 1'b0;
      wr_ready   <= 1'b1;
      busy       <= 1'b0;
      flush      <= 1'b0;
      yn_valid   <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      commit_err <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (wr_fire) shadow[wr_addr] <= wr_data;
          if (commit) begin
            mask <= mask_next;
            if (&mask_next) begin
              state    <= SWAP;
              wr_ready <= 1'b0;
              busy     <= 1'b1;
              yn_valid <= 1'b0;
            end else begin
              commit_err <= 1'b1;
              if (wr_fire) state <= LOAD;
            end
          end else if (abort && state == LOAD) begin
            mask  <= '0;
            state <= IDLE;
          end else if (wr_fire) begin
            mask  <= mask_next;
            state <= LOAD;
          end
        end
        SWAP: begin
          for (int unsigned i = 0; i < NTAPS; i++) active[i] <= shadow[i];
          mask      <= '0;
          swap_cnt  <= swap_cnt + 8'd1;
          flush_cnt <= CW'(FLUSH_LEN - 1);
          flush     <= 1'b1;
          state     <= FLUSH;
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            flush    <= 1'b0;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            yn_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_COEF_READBACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < NTAPS) begin
      rd_data <= active[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed self-checking bench for fir_coef_ctrl (default 16 taps x 16 bits, flush 19).
module tb_fir_coef_ctrl;

  localparam int NTAPS = 16;
  localparam int DW    = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_valid;
  logic                wr_ready;
  logic [3:0]          wr_addr;
  logic [DW-1:0]       wr_data;
  logic                commit;
  logic                abort;
  logic                commit_err;
  logic [NTAPS*DW-1:0] coef_o;
  logic                flush;
  logic                yn_valid;
  logic                busy;
  logic [7:0]          swap_cnt;
`ifdef FIR_COEF_READBACK_EN
  logic [3:0]          rd_addr;
  logic [DW-1:0]       rd_data;
`endif

  int checks   = 0;
  int failures = 0;

  fir_coef_ctrl #(.NTAPS(NTAPS), .DW(DW), .FLUSH_LEN(19)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .abort      (abort),
    .commit_err (commit_err),
    .coef_o     (coef_o),
    .flush      (flush),
    .yn_valid   (yn_valid),
    .busy       (busy),
    .swap_cnt   (swap_cnt)
`ifdef FIR_COEF_READBACK_EN
    ,
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] tap(input int i);
    return coef_o[DW*i +: DW];
  endfunction

  task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int busy_n, flush_n, yn_first;
    logic err_seen;

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; abort = 1'b0;
`ifdef FIR_COEF_READBACK_EN
    rd_addr = '0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_coef", coef_o, 0);
    chk("rst_flush", flush, 0);
    chk("rst_yn", yn_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", commit_err, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_cnt", swap_cnt, 0);

    // Full load: tap i = 0x0100*i, then commit
    for (int i = 0; i < NTAPS; i++) wr(4'(i), 16'(16'h0100 * i));
    chk("load_ready", wr_ready, 1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    busy_n = 0; flush_n = 0; yn_first = 0; err_seen = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (busy) busy_n++;
      if (flush) flush_n++;
      if (yn_valid && yn_first == 0) yn_first = c;
      if (commit_err) err_seen = 1'b1;
      if (c == 1) begin
        chk("swap_coef_hold", coef_o, 0);
        chk("swap_ready", wr_ready, 0);
        chk("swap_flush", flush, 0);
      end
      if (c == 2) chk("flush_tap5", tap(5), 16'h0500);
      // commit and write during FLUSH must be ignored
      if (c == 5) begin
        commit = 1'b1; wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
      end
      if (c == 6) begin
        commit = 1'b0; wr_valid = 1'b0;
      end
      tick();
    end
    chk("full_busy_cycles", busy_n, 20);
    chk("full_flush_cycles", flush_n, 19);
    chk("full_yn_first", yn_first, 21);
    chk("full_no_err", err_seen, 0);
    chk("full_tap5", tap(5), 16'h0500);
    chk("full_tap15", tap(15), 16'h0F00);
    chk("full_tap0", tap(0), 16'h0000);
    chk("full_swap_cnt", swap_cnt, 1);

`ifdef FIR_COEF_READBACK_EN
    rd_addr = 4'd3;
    tick();
    chk("rd_tap3", rd_data, 16'h0300);
    rd_addr = 4'd0;
    tick();
    chk("rd_tap0", rd_data, 16'h0000);
`endif

    // Partial commit: taps 0..14 only
    for (int i = 0; i < NTAPS - 1; i++) wr(4'(i), 16'(16'hA000 + i));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("part_err", commit_err, 1);
    chk("part_busy", busy, 0);
    chk("part_tap5", tap(5), 16'h0500);
    chk("part_yn", yn_valid, 1);
    tick();
    chk("part_err_pulse", commit_err, 0);

    // Same-cycle write of tap 15 with commit completes the mask
    wr_valid = 1'b1; wr_addr = 4'd15; wr_data = 16'h7FFF; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    chk("same_busy", busy, 1);
    chk("same_err", commit_err, 0);
    chk("same_yn_low", yn_valid, 0);
    for (int c = 0; c < 20; c++) tick();
    chk("same_tap15", tap(15), 16'h7FFF);
    chk("same_tap3", tap(3), 16'hA003);
    chk("same_cnt", swap_cnt, 2);
    chk("same_yn", yn_valid, 1);

    // Abort in LOAD, then commit with an empty mask
    wr(4'd2, 16'h1234);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("abort_err", commit_err, 1);
    chk("abort_busy", busy, 0);

    // Rewrite tap 0, fill all taps, then commit+abort together
    wr(4'd0, 16'hDEAD);
    for (int i = 0; i < NTAPS; i++) wr(4'(i), 16'(16'h0010 + i));
    commit = 1'b1; abort = 1'b1;
    tick();
    commit = 1'b0; abort = 1'b0;
    chk("prio_busy", busy, 1);
    chk("prio_err", commit_err, 0);
    for (int c = 0; c < 20; c++) tick();
    chk("prio_cnt", swap_cnt, 3);
    chk("prio_tap0", tap(0), 16'h0010);
    chk("prio_tap2", tap(2), 16'h0012);
    chk("prio_tap7", tap(7), 16'h0017);

    // Reset applied at flush cycle 7
    for (int i = 0; i < NTAPS; i++) wr(4'(i), 16'h5555);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    for (int c = 1; c < 7; c++) tick();
    chk("mid_flush", flush, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_coef", coef_o, 0);
    chk("mrst_flush", flush, 0);
    chk("mrst_yn", yn_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", wr_ready, 1);
    chk("mrst_cnt", swap_cnt, 0);
    tick();
    chk("mrst_flush_hold", flush, 0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("mrst_commit_err", commit_err, 1);
    chk("mrst_yn_hold", yn_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
